apb2axi_burst_splitter: RTL and testbench

Parametrised successor to the bridge's single-burst transaction routing. It accepts one directory request of arbitrary length (up to 2^BEATS_W-1 beats) and emits a sequence of legal AXI3 bursts. Each burst is at most MAX_BURST beats and never crosses a BOUNDARY-byte address boundary. Segments go to the write or read request FIFO according to direction, and the block reports the segment count per tag so the response collector knows how many completions to expect.

---
 rtl/apb2axi_burst_splitter_pkg.sv | 22 ++
 rtl/apb2axi_seg_calc.sv | 44 ++++
 rtl/apb2axi_burst_splitter.sv | 159 +++++++++++++++
 tb/tb_apb2axi_burst_splitter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/apb2axi_burst_splitter_pkg.sv
// Shared types and constants for the APB-to-AXI burst splitter and its helpers.
// seg_req_t is the canonical segment record used by downstream FIFO wrappers.
package apb2axi_burst_splitter_pkg;

    localparam int MAX_AXI3_LEN    = 16;
    localparam int AXI_4K_BOUNDARY = 4096;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  len;
        logic [2:0]  size;
        logic [3:0]  tag;
        logic        first;
        logic        last;
    } seg_req_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SPLIT = 1'b1
    } state_t;

endpackage

// File: rtl/apb2axi_seg_calc.sv
// Combinational segment sizing: beats of the next burst, limited by the remaining
// count, the AXI3 burst cap and the distance to the next address boundary.
module apb2axi_seg_calc
    import apb2axi_burst_splitter_pkg::*;
#(
    parameter int AXI_ADDR_W = 32,
    parameter int BEATS_W    = 8,
    parameter int MAX_BURST  = MAX_AXI3_LEN,
    parameter int BOUNDARY   = AXI_4K_BOUNDARY
) (
    input  logic [AXI_ADDR_W-1:0] addr,
    input  logic [BEATS_W-1:0]    remaining,
    input  logic [2:0]            size,
    output logic [4:0]            seg_beats,
    output logic                  seg_last
);

    logic [AXI_ADDR_W:0] offs;
    logic [AXI_ADDR_W:0] bound_bytes;
    logic [AXI_ADDR_W:0] bound_beats;
    logic [AXI_ADDR_W:0] rem_w;
    logic [AXI_ADDR_W:0] beats_w;

    always_comb begin
        offs        = {1'b0, addr & AXI_ADDR_W'(BOUNDARY - 1)};
        bound_bytes = (AXI_ADDR_W + 1)'(BOUNDARY) - offs;
        bound_beats = bound_bytes >> size;

        rem_w                = '0;
        rem_w[BEATS_W-1:0]   = remaining;

        beats_w = rem_w;
        if ((AXI_ADDR_W + 1)'(MAX_BURST) < beats_w) begin
            beats_w = (AXI_ADDR_W + 1)'(MAX_BURST);
        end
        if (bound_beats < beats_w) begin
            beats_w = bound_beats;
        end

        seg_beats = 5'(beats_w);
        seg_last  = (rem_w == beats_w);
    end

endmodule

// File: rtl/apb2axi_burst_splitter.sv
// Splits one directory request into legal AXI3 bursts (length cap, no boundary
// crossing) and routes them to the write or read request FIFO.
module apb2axi_burst_splitter
    import apb2axi_burst_splitter_pkg::*;
#(
    parameter int AXI_ADDR_W = 32,
    parameter int AXI_DATA_W = 32,
    parameter int TAG_W      = 4,
    parameter int BEATS_W    = 8,
    parameter int MAX_BURST  = MAX_AXI3_LEN,
    parameter int BOUNDARY   = AXI_4K_BOUNDARY
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_is_write,
    input  logic [AXI_ADDR_W-1:0] in_addr,
    input  logic [BEATS_W-1:0]    in_beats,
    input  logic [2:0]            in_size,
    input  logic [TAG_W-1:0]      in_tag,
    output logic                  wr_push_valid,
    input  logic                  wr_push_ready,
    output logic                  rd_push_valid,
    input  logic                  rd_push_ready,
    output logic [AXI_ADDR_W-1:0] seg_addr,
    output logic [3:0]            seg_len,
    output logic [2:0]            seg_size,
    output logic [TAG_W-1:0]      seg_tag,
    output logic                  seg_first,
    output logic                  seg_last,
    output logic                  done_valid,
    output logic [TAG_W-1:0]      done_tag,
    output logic [BEATS_W-1:0]    done_segs,
    output logic                  err_valid,
    output logic [TAG_W-1:0]      err_tag
);

    localparam int MAX_SIZE = $clog2(AXI_DATA_W / 8);

    state_t                state_q, state_d;
    logic [AXI_ADDR_W-1:0] addr_q;
    logic [BEATS_W-1:0]    rem_q;
    logic [2:0]            size_q;
    logic [TAG_W-1:0]      tag_q;
    logic                  dir_q;
    logic [BEATS_W-1:0]    seg_cnt_q;

    logic [AXI_ADDR_W-1:0] align_mask;
    logic                  illegal;
    logic                  accept;
    logic                  handshake;
    logic [4:0]            calc_beats;
    logic                  calc_last;

    apb2axi_seg_calc #(
        .AXI_ADDR_W (AXI_ADDR_W),
        .BEATS_W    (BEATS_W),
        .MAX_BURST  (MAX_BURST),
        .BOUNDARY   (BOUNDARY)
    ) u_seg_calc (
        .addr       (addr_q),
        .remaining  (rem_q),
        .size       (size_q),
        .seg_beats  (calc_beats),
        .seg_last   (calc_last)
    );

    always_comb begin
        align_mask = (AXI_ADDR_W'(1) << in_size) - AXI_ADDR_W'(1);
        illegal    = (in_beats == '0) || (in_size > 3'(MAX_SIZE)) ||
                     ((in_addr & align_mask) != '0);
        accept     = in_valid && (state_q == ST_IDLE);
        handshake  = (state_q == ST_SPLIT) && (dir_q ? wr_push_ready : rd_push_ready);
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept && !illegal)    state_d = ST_SPLIT;
            ST_SPLIT: if (handshake && calc_last) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready      = (state_q == ST_IDLE);
        wr_push_valid = 1'b0;
        rd_push_valid = 1'b0;
        seg_addr      = '0;
        seg_len       = '0;
        seg_size      = '0;
        seg_tag       = '0;
        seg_first     = 1'b0;
        seg_last      = 1'b0;
        if (state_q == ST_SPLIT) begin
            wr_push_valid = dir_q;
            rd_push_valid = !dir_q;
            seg_addr      = addr_q;
            seg_len       = 4'(calc_beats - 5'd1);
            seg_size      = size_q;
            seg_tag       = tag_q;
            seg_first     = (seg_cnt_q == '0);
            seg_last      = calc_last;
        end
    end

    // Datapath; pulses are single-cycle and cleared by default
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            addr_q     <= '0;
            rem_q      <= '0;
            size_q     <= '0;
            tag_q      <= '0;
            dir_q      <= 1'b0;
            seg_cnt_q  <= '0;
            done_valid <= 1'b0;
            done_tag   <= '0;
            done_segs  <= '0;
            err_valid  <= 1'b0;
            err_tag    <= '0;
        end else begin
            done_valid <= 1'b0;
            err_valid  <= 1'b0;
            if (accept) begin
                if (illegal) begin
                    err_valid <= 1'b1;
                    err_tag   <= in_tag;
                end else begin
                    addr_q    <= in_addr;
                    rem_q     <= in_beats;
                    size_q    <= in_size;
                    tag_q     <= in_tag;
                    dir_q     <= in_is_write;
                    seg_cnt_q <= '0;
                end
            end
            if (handshake) begin
                addr_q    <= addr_q + (AXI_ADDR_W'(calc_beats) << size_q);
                rem_q     <= rem_q - BEATS_W'(calc_beats);
                seg_cnt_q <= seg_cnt_q + BEATS_W'(1);
                if (calc_last) begin
                    done_valid <= 1'b1;
                    done_tag   <= tag_q;
                    done_segs  <= seg_cnt_q + BEATS_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_apb2axi_burst_splitter.sv
// Directed bench for apb2axi_burst_splitter: hand-computed segment lists,
// backpressure, illegal requests and mid-request reset.
module tb_apb2axi_burst_splitter;

    logic        aclk;
    logic        aresetn;
    logic        in_valid;
    logic        in_ready;
    logic        in_is_write;
    logic [31:0] in_addr;
    logic [7:0]  in_beats;
    logic [2:0]  in_size;
    logic [3:0]  in_tag;
    logic        wr_push_valid, wr_push_ready;
    logic        rd_push_valid, rd_push_ready;
    logic [31:0] seg_addr;
    logic [3:0]  seg_len;
    logic [2:0]  seg_size;
    logic [3:0]  seg_tag;
    logic        seg_first, seg_last;
    logic        done_valid;
    logic [3:0]  done_tag;
    logic [7:0]  done_segs;
    logic        err_valid;
    logic [3:0]  err_tag;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  len;
        logic        first;
        logic        last;
    } seg_t;

    seg_t        seg_q[$];
    logic [11:0] done_q[$];

    apb2axi_burst_splitter dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_is_write   (in_is_write),
        .in_addr       (in_addr),
        .in_beats      (in_beats),
        .in_size       (in_size),
        .in_tag        (in_tag),
        .wr_push_valid (wr_push_valid),
        .wr_push_ready (wr_push_ready),
        .rd_push_valid (rd_push_valid),
        .rd_push_ready (rd_push_ready),
        .seg_addr      (seg_addr),
        .seg_len       (seg_len),
        .seg_size      (seg_size),
        .seg_tag       (seg_tag),
        .seg_first     (seg_first),
        .seg_last      (seg_last),
        .done_valid    (done_valid),
        .done_tag      (done_tag),
        .done_segs     (done_segs),
        .err_valid     (err_valid),
        .err_tag       (err_tag)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge aclk) begin
        if (wr_push_valid && rd_push_valid) chk("both_push_valid", 1, 0);
        if ((wr_push_valid && wr_push_ready) || (rd_push_valid && rd_push_ready))
            seg_q.push_back('{wr: wr_push_valid, addr: seg_addr, len: seg_len,
                              first: seg_first, last: seg_last});
        if (done_valid) done_q.push_back({done_tag, done_segs});
    end

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic send(input logic wr, input logic [31:0] addr, input logic [7:0] beats,
                        input logic [2:0] size, input logic [3:0] tag);
        in_valid    = 1'b1;
        in_is_write = wr;
        in_addr     = addr;
        in_beats    = beats;
        in_size     = size;
        in_tag      = tag;
        step();
        in_valid    = 1'b0;
    endtask

    task automatic expect_done(input string nm, input logic [3:0] tag, input logic [7:0] segs);
        int   n = 0;
        logic [11:0] d;
        while (done_q.size() == 0 && n < 200) begin
            step();
            n++;
        end
        if (done_q.size() == 0) begin
            chk({nm, "_done_timeout"}, 1, 0);
        end else begin
            d = done_q.pop_front();
            chk({nm, "_done_tag"}, d[11:8], tag);
            chk({nm, "_done_segs"}, d[7:0], segs);
        end
    endtask

    task automatic expect_seg(input string nm, input logic wr, input logic [31:0] addr,
                              input logic [3:0] len, input logic first, input logic last);
        seg_t s;
        seg_t e;
        e = '{wr: wr, addr: addr, len: len, first: first, last: last};
        if (seg_q.size() == 0) begin
            chk({nm, "_missing"}, 1, 0);
        end else begin
            s = seg_q.pop_front();
            chk(nm, s, e);
        end
    endtask

    initial begin
        aresetn       = 1'b0;
        in_valid      = 1'b0;
        in_is_write   = 1'b0;
        in_addr       = '0;
        in_beats      = '0;
        in_size       = '0;
        in_tag        = '0;
        wr_push_ready = 1'b1;
        rd_push_ready = 1'b1;
        repeat (3) step();

        chk("rst_in_ready", in_ready, 1);
        chk("rst_push_valid", {wr_push_valid, rd_push_valid}, 0);
        chk("rst_seg", {seg_addr, seg_len, seg_size, seg_tag, seg_first, seg_last}, 0);
        chk("rst_pulses", {done_valid, err_valid, done_tag, done_segs, err_tag}, 0);
        aresetn = 1'b1;
        step();

        // single segment write
        send(1'b1, 32'h1000, 8'd8, 3'd2, 4'd3);
        chk("t1_wr_valid", wr_push_valid, 1);
        chk("t1_in_ready_busy", in_ready, 0);
        chk("t1_seg_size_tag", {seg_size, seg_tag}, {3'd2, 4'd3});
        expect_done("t1", 4'd3, 8'd1);
        chk("t1_in_ready_back", in_ready, 1);
        expect_seg("t1_seg0", 1'b1, 32'h1000, 4'd7, 1'b1, 1'b1);
        chk("t1_extra", seg_q.size(), 0);

        // 40-beat read -> 16 + 16 + 8
        send(1'b0, 32'h2000, 8'd40, 3'd2, 4'd5);
        expect_done("t2", 4'd5, 8'd3);
        expect_seg("t2_seg0", 1'b0, 32'h2000, 4'd15, 1'b1, 1'b0);
        expect_seg("t2_seg1", 1'b0, 32'h2040, 4'd15, 1'b0, 1'b0);
        expect_seg("t2_seg2", 1'b0, 32'h2080, 4'd7,  1'b0, 1'b1);
        chk("t2_extra", seg_q.size(), 0);

        // 4 KiB crossing
        send(1'b1, 32'h0FF0, 8'd8, 3'd2, 4'd6);
        expect_done("t3", 4'd6, 8'd2);
        expect_seg("t3_seg0", 1'b1, 32'h0FF0, 4'd3, 1'b1, 1'b0);
        expect_seg("t3_seg1", 1'b1, 32'h1000, 4'd3, 1'b0, 1'b1);
        chk("t3_extra", seg_q.size(), 0);

        // backpressure on segment 2
        send(1'b1, 32'h3000, 8'd40, 3'd2, 4'd7);
        step();
        wr_push_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t4_stall_valid", wr_push_valid, 1);
            chk("t4_stall_seg", {seg_addr, seg_len, seg_first, seg_last},
                {32'h3040, 4'd15, 1'b0, 1'b0});
            chk("t4_stall_in_ready", in_ready, 0);
        end
        wr_push_ready = 1'b1;
        expect_done("t4", 4'd7, 8'd3);
        expect_seg("t4_seg0", 1'b1, 32'h3000, 4'd15, 1'b1, 1'b0);
        expect_seg("t4_seg1", 1'b1, 32'h3040, 4'd15, 1'b0, 1'b0);
        expect_seg("t4_seg2", 1'b1, 32'h3080, 4'd7,  1'b0, 1'b1);
        chk("t4_extra", seg_q.size(), 0);

        // illegal requests: oversize, zero beats, misaligned
        send(1'b1, 32'h1000, 8'd4, 3'd3, 4'd9);
        chk("t5a_err", {err_valid, err_tag}, {1'b1, 4'd9});
        chk("t5a_in_ready", in_ready, 1);
        chk("t5a_no_push", {wr_push_valid, rd_push_valid}, 0);
        step();
        chk("t5a_err_pulse", err_valid, 0);
        send(1'b0, 32'h1000, 8'd0, 3'd2, 4'd10);
        chk("t5b_err", {err_valid, err_tag}, {1'b1, 4'd10});
        chk("t5b_no_push", {wr_push_valid, rd_push_valid}, 0);
        step();
        send(1'b1, 32'h1002, 8'd4, 3'd2, 4'd11);
        chk("t5c_err", {err_valid, err_tag}, {1'b1, 4'd11});
        chk("t5c_in_ready", in_ready, 1);
        step();
        chk("t5_no_seg", seg_q.size(), 0);
        chk("t5_no_done", done_q.size(), 0);

        // reset during segment 2 of 3
        send(1'b0, 32'h2000, 8'd40, 3'd2, 4'd12);
        step();
        chk("t6_seg1_addr", {seg_addr, seg_first}, {32'h2040, 1'b0});
        aresetn       = 1'b0;
        rd_push_ready = 1'b0;
        step();
        chk("t6_rst_valid", {wr_push_valid, rd_push_valid}, 0);
        chk("t6_rst_in_ready", in_ready, 1);
        chk("t6_rst_seg", {seg_addr, seg_len}, 0);
        step();
        aresetn       = 1'b1;
        rd_push_ready = 1'b1;
        repeat (5) step();
        chk("t6_no_done", done_q.size(), 0);
        chk("t6_seg_log", seg_q.size(), 1);
        seg_q.delete();
        send(1'b0, 32'h0FF0, 8'd8, 3'd2, 4'd13);
        chk("t6_new_first", seg_first, 1);
        expect_done("t6", 4'd13, 8'd2);
        expect_seg("t6_seg0", 1'b0, 32'h0FF0, 4'd3, 1'b1, 1'b0);
        expect_seg("t6_seg1", 1'b0, 32'h1000, 4'd3, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
